write_back_cache: RTL and testbench

WRITE_BACK_CACHE -- requirements
Module: write_back_cache

---
 rtl/write_back_cache.sv | 175 +++++++++++++++++
 tb/tb_write_back_cache.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_cache.sv
`default_nettype none
// ============================================================================
// Module   : write_back_cache
// Brief    : Direct-mapped cache with line eviction/fill over a word-serial
//            memory port; write-back/allocate or write-through/no-allocate.
// Revision : 1.0
// ============================================================================
module write_back_cache #(
  parameter int INDEX_BITS   = 5,
  parameter int BLOCK_OFFSET = 6,
  parameter int WORD_SIZE    = 32,
  parameter int WRITE_BACK   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  input  logic                 wr,
  input  logic                 re,
  input  logic                 enable,
  output logic                 stall,
  output logic [31:0]          ext_addr,
  output logic [WORD_SIZE-1:0] ext_data_out,
  input  logic [WORD_SIZE-1:0] ext_data_in,
  output logic                 ext_wr,
  output logic                 ext_re,
  input  logic                 ext_ack
);

  localparam int CACHE_LINES    = 2**INDEX_BITS;
  localparam int DATA_LENGTH    = 2**BLOCK_OFFSET;
  localparam int WORDS_PER_LINE = DATA_LENGTH*8/WORD_SIZE;
  localparam int TAG_BITS       = 32-INDEX_BITS-BLOCK_OFFSET;
  localparam int WORD_SEL       = $clog2(WORDS_PER_LINE);
  localparam int BYTE_BITS      = BLOCK_OFFSET-WORD_SEL;
  localparam int RAM_BITS       = INDEX_BITS+WORD_SEL;

  localparam logic [WORD_SEL-1:0] LAST_WORD = WORD_SEL'(WORDS_PER_LINE-1);
  localparam logic [WORD_SEL-1:0] CNT_ONE   = WORD_SEL'(1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EVICT    = 2'd1;
  localparam logic [1:0] S_FILL     = 2'd2;
  localparam logic [1:0] S_WT_WRITE = 2'd3;

  logic [CACHE_LINES-1:0] valid_q;
  logic [CACHE_LINES-1:0] dirty_q;
  logic [TAG_BITS-1:0]    tag_q  [CACHE_LINES];
  logic [WORD_SIZE-1:0]   data_q [2**RAM_BITS];

  logic [1:0]            state_q, state_d;
  logic [WORD_SEL-1:0]   cnt_q, cnt_d;
  logic [31-BYTE_BITS:0] req_q;
  logic [WORD_SIZE-1:0]  req_data_q;

  logic [INDEX_BITS-1:0] cpu_idx, req_idx;
  logic [TAG_BITS-1:0]   cpu_tag, req_tag;
  logic [WORD_SEL-1:0]   cpu_word;
  logic                  hit, access, cpu_wr_hit, last_ack;
  logic                  unused_addr_bits;

  assign cpu_idx  = addr[BLOCK_OFFSET +: INDEX_BITS];
  assign cpu_tag  = addr[31 -: TAG_BITS];
  assign cpu_word = addr[BYTE_BITS +: WORD_SEL];
  // The line transaction works from the address captured when IDLE was left,
  // so a request that changes mid-transaction cannot redirect it.
  assign req_idx  = req_q[WORD_SEL +: INDEX_BITS];
  assign req_tag  = req_q[31-BYTE_BITS -: TAG_BITS];

  assign hit        = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign access     = enable && (wr || re);
  assign cpu_wr_hit = (state_q == S_IDLE) && access && wr && hit;
  assign last_ack   = ext_ack && (cnt_q == LAST_WORD);
  assign data_out   = data_q[{cpu_idx, cpu_word}];
  assign unused_addr_bits = ^addr[BYTE_BITS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      req_data_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE) begin
        req_q      <= addr[31:BYTE_BITS];
        req_data_q <= data_in;
      end
      if (cpu_wr_hit && (WRITE_BACK != 0)) dirty_q[cpu_idx] <= 1'b1;
      if ((state_q == S_EVICT) && last_ack) dirty_q[req_idx] <= 1'b0;
      if ((state_q == S_FILL) && last_ack) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_wr_hit) data_q[{cpu_idx, cpu_word}] <= data_in;
    if ((state_q == S_FILL) && ext_ack) data_q[{req_idx, cnt_q}] <= ext_data_in;
    if ((state_q == S_FILL) && last_ack) tag_q[req_idx] <= req_tag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (wr && (WRITE_BACK == 0)) state_d = S_WT_WRITE;
          else if (!hit) state_d = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? S_EVICT : S_FILL;
        end
      end
      S_EVICT: begin
        if (ext_ack) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_WORD) state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (ext_ack) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_WORD) state_d = S_IDLE;
        end
      end
      S_WT_WRITE: begin
        if (ext_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall        = 1'b0;
    ext_wr       = 1'b0;
    ext_re       = 1'b0;
    ext_addr     = '0;
    ext_data_out = '0;
    case (state_q)
      S_IDLE: stall = access && (!hit || (wr && (WRITE_BACK == 0)));
      S_EVICT: begin
        stall        = 1'b1;
        ext_wr       = 1'b1;
        ext_addr     = {tag_q[req_idx], req_idx, cnt_q, {BYTE_BITS{1'b0}}};
        ext_data_out = data_q[{req_idx, cnt_q}];
      end
      S_FILL: begin
        stall    = 1'b1;
        ext_re   = 1'b1;
        ext_addr = {req_tag, req_idx, cnt_q, {BYTE_BITS{1'b0}}};
      end
      S_WT_WRITE: begin
        // Released in the ack cycle so the CPU can retire the store at once.
        stall        = !ext_ack;
        ext_wr       = 1'b1;
        ext_addr     = {req_q, {BYTE_BITS{1'b0}}};
        ext_data_out = req_data_q;
      end
      default: ;
    endcase
    if (rst) begin
      stall        = 1'b0;
      ext_wr       = 1'b0;
      ext_re       = 1'b0;
      ext_addr     = '0;
      ext_data_out = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_write_back_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_back_cache
// Brief    : Directed bench for write_back_cache, write-back and write-through.
// Revision : 1.0
// ============================================================================
module tb_write_back_cache;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  typedef struct {
    logic        wr;
    logic        re;
    logic        en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] a_addr, a_din, a_dout, a_ext_addr, a_ext_dout, a_ext_din;
  logic        a_wr, a_re, a_en, a_stall, a_ext_wr, a_ext_re, a_ack;
  logic [31:0] b_addr, b_din, b_dout, b_ext_addr, b_ext_dout, b_ext_din;
  logic        b_wr, b_re, b_en, b_stall, b_ext_wr, b_ext_re, b_ack;

  assign a_ext_din = memf(a_ext_addr);
  assign b_ext_din = memf(b_ext_addr);

  write_back_cache #(.INDEX_BITS(5), .BLOCK_OFFSET(6), .WORD_SIZE(32), .WRITE_BACK(1)) u_wb (
    .clk(clk), .rst(rst), .addr(a_addr), .data_in(a_din), .data_out(a_dout),
    .wr(a_wr), .re(a_re), .enable(a_en), .stall(a_stall), .ext_addr(a_ext_addr),
    .ext_data_out(a_ext_dout), .ext_data_in(a_ext_din), .ext_wr(a_ext_wr),
    .ext_re(a_ext_re), .ext_ack(a_ack)
  );

  write_back_cache #(.INDEX_BITS(5), .BLOCK_OFFSET(6), .WORD_SIZE(32), .WRITE_BACK(0)) u_wt (
    .clk(clk), .rst(rst), .addr(b_addr), .data_in(b_din), .data_out(b_dout),
    .wr(b_wr), .re(b_re), .enable(b_en), .stall(b_stall), .ext_addr(b_ext_addr),
    .ext_data_out(b_ext_dout), .ext_data_in(b_ext_din), .ext_wr(b_ext_wr),
    .ext_re(b_ext_re), .ext_ack(b_ack)
  );

  xfer_t a_log[$];
  xfer_t b_log[$];
  int    a_both = 0;
  int    b_both = 0;

  // Memory-side monitor: records every word completed on an acked edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (a_ack && a_ext_wr) a_log.push_back('{1'b1, a_ext_addr, a_ext_dout});
      if (a_ack && a_ext_re) a_log.push_back('{1'b0, a_ext_addr, a_ext_din});
      if (b_ack && b_ext_wr) b_log.push_back('{1'b1, b_ext_addr, b_ext_dout});
      if (b_ack && b_ext_re) b_log.push_back('{1'b0, b_ext_addr, b_ext_din});
      if (a_ext_wr && a_ext_re) a_both <= a_both + 1;
      if (b_ext_wr && b_ext_re) b_both <= b_both + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(input string nm);
    int n = 0;
    while (a_stall !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk({nm, " completes"}, {31'b0, a_stall}, 32'd0);
  endtask

  task automatic wait_b(input string nm);
    int n = 0;
    while (b_stall !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk({nm, " completes"}, {31'b0, b_stall}, 32'd0);
  endtask

  task automatic count_log(input xfer_t q[$], output int nw, output int nr);
    nw = 0;
    nr = 0;
    foreach (q[i]) begin
      if (q[i].w) nw++;
      else nr++;
    end
  endtask

  vec_t vt[12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nw, nr;

    // Line at index 1 holds tag 2 (0x1040) when the table runs.
    vt[0]  = '{1'b0, 1'b1, 1'b1, 32'h1040, 32'h0,         1'b0, 1'b1, memf(32'h1040)};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h1044, 32'h0,         1'b0, 1'b1, memf(32'h1044)};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h107C, 32'h0,         1'b0, 1'b1, memf(32'h107C)};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h1046, 32'h0,         1'b0, 1'b1, memf(32'h1044)};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 32'h1044, 32'hDEADBEEF,  1'b0, 1'b0, 32'h0};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 32'h1044, 32'h0,         1'b0, 1'b1, 32'hDEADBEEF};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 32'h1048, 32'h0,         1'b0, 1'b1, memf(32'h1048)};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 32'h1048, 32'h12345678,  1'b0, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 32'h1048, 32'h0,         1'b0, 1'b1, 32'h12345678};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 32'h5000, 32'h0,         1'b0, 1'b0, 32'h0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 32'h3040, 32'h0,         1'b0, 1'b0, 32'h0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 32'h3040, 32'h0,         1'b0, 1'b0, 32'h0};

    rst = 1'b1;
    a_wr = 1'b0; a_re = 1'b1; a_en = 1'b1; a_addr = 32'h1040; a_din = '0; a_ack = 1'b1;
    b_wr = 1'b0; b_re = 1'b0; b_en = 1'b0; b_addr = '0;       b_din = '0; b_ack = 1'b0;

    // Reset forces quiet outputs even with a miss request pending.
    repeat (2) tick();
    chk("reset stall", {31'b0, a_stall}, 32'd0);
    chk("reset strobes", {30'b0, a_ext_wr, a_ext_re}, 32'd0);
    chk("reset ext_addr", a_ext_addr, 32'd0);
    chk("reset ext_data_out", a_ext_dout, 32'd0);

    rst = 1'b0;
    a_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("disabled stall c%0d", i), {31'b0, a_stall}, 32'd0);
      chk($sformatf("disabled strobes c%0d", i), {30'b0, a_ext_wr, a_ext_re}, 32'd0);
      tick();
    end

    // Cold read miss fills the whole line.
    a_log.delete();
    a_en = 1'b1;
    #1;
    chk("cold miss stall", {31'b0, a_stall}, 32'd1);
    wait_a("cold fill");
    chk("cold fill words", a_log.size(), 32'd16);
    foreach (a_log[i]) begin
      chk($sformatf("cold fill kind %0d", i), {31'b0, a_log[i].w}, 32'd0);
      chk($sformatf("cold fill addr %0d", i), a_log[i].a, 32'h1040 + 32'(i*4));
    end
    chk("cold fill data_out", a_dout, memf(32'h1040));

    foreach (vt[i]) begin
      a_wr = vt[i].wr; a_re = vt[i].re; a_en = vt[i].en;
      a_addr = vt[i].addr; a_din = vt[i].wdata;
      #1;
      chk($sformatf("vec%0d stall", i), {31'b0, a_stall}, {31'b0, vt[i].exp_stall});
      chk($sformatf("vec%0d strobes", i), {30'b0, a_ext_wr, a_ext_re}, 32'd0);
      if (vt[i].chk_data) chk($sformatf("vec%0d data_out", i), a_dout, vt[i].exp_data);
      tick();
    end

    // Conflict miss on the dirty line: full eviction, then fill.
    a_log.delete();
    a_wr = 1'b0; a_re = 1'b1; a_en = 1'b1; a_addr = 32'h3040;
    #1;
    chk("evict miss stall", {31'b0, a_stall}, 32'd1);
    wait_a("evict+fill");
    chk("evict+fill words", a_log.size(), 32'd32);
    foreach (a_log[i]) begin
      if (i < 16) begin
        chk($sformatf("evict kind %0d", i), {31'b0, a_log[i].w}, 32'd1);
        chk($sformatf("evict addr %0d", i), a_log[i].a, 32'h1040 + 32'(i*4));
        chk($sformatf("evict data %0d", i), a_log[i].d,
            (i == 1) ? 32'hDEADBEEF : (i == 2) ? 32'h12345678 : memf(32'h1040 + 32'(i*4)));
      end else begin
        chk($sformatf("refill kind %0d", i), {31'b0, a_log[i].w}, 32'd0);
        chk($sformatf("refill addr %0d", i), a_log[i].a, 32'h3040 + 32'((i-16)*4));
      end
    end
    chk("evict+fill data_out", a_dout, memf(32'h3040));

    // Memory backpressure in the middle of a fill.
    a_addr = 32'h5080;
    #1;
    chk("bp miss stall", {31'b0, a_stall}, 32'd1);
    tick();
    chk("bp fill word0 addr", a_ext_addr, 32'h5080);
    tick();
    tick();
    chk("bp fill word2 addr", a_ext_addr, 32'h5088);
    a_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp hold addr %0d", i), a_ext_addr, 32'h5088);
      chk($sformatf("bp hold stall/re %0d", i), {30'b0, a_stall, a_ext_re}, 32'd3);
    end
    a_ack = 1'b1;
    tick();
    chk("bp resume addr", a_ext_addr, 32'h508C);
    wait_a("bp fill");
    chk("bp data_out w0", a_dout, memf(32'h5080));
    a_addr = 32'h5088;
    #1;
    chk("bp data_out w2", a_dout, memf(32'h5088));

    // Reset in the middle of an eviction.
    a_wr = 1'b1; a_re = 1'b0; a_addr = 32'h3044; a_din = 32'h0BADF00D;
    #1;
    chk("dirty write hit stall", {31'b0, a_stall}, 32'd0);
    tick();
    a_wr = 1'b0; a_re = 1'b1; a_addr = 32'h7040;
    #1;
    chk("evict2 miss stall", {31'b0, a_stall}, 32'd1);
    tick();
    repeat (7) tick();
    chk("evict2 word7 strobe", {31'b0, a_ext_wr}, 32'd1);
    chk("evict2 word7 addr", a_ext_addr, 32'h305C);
    chk("evict2 word7 data", a_ext_dout, memf(32'h305C));
    #2;
    rst = 1'b1;
    #1;
    chk("async rst strobes", {30'b0, a_ext_wr, a_ext_re}, 32'd0);
    chk("async rst stall", {31'b0, a_stall}, 32'd0);
    chk("async rst ext_addr", a_ext_addr, 32'd0);
    chk("async rst ext_data_out", a_ext_dout, 32'd0);
    tick();
    rst = 1'b0;
    a_log.delete();
    a_addr = 32'h3044;
    #1;
    chk("post-rst miss stall", {31'b0, a_stall}, 32'd1);
    wait_a("post-rst fill");
    count_log(a_log, nw, nr);
    chk("post-rst writes", nw, 32'd0);
    chk("post-rst reads", nr, 32'd16);
    chk("post-rst data_out", a_dout, memf(32'h3044));
    a_re = 1'b0;

    // Write-through, no-write-allocate instance.
    b_log.delete();
    b_en = 1'b1; b_wr = 1'b1; b_addr = 32'h2000; b_din = 32'hCAFEF00D; b_ack = 1'b0;
    #1;
    chk("wt miss stall", {31'b0, b_stall}, 32'd1);
    tick();
    chk("wt strobe", {30'b0, b_ext_wr, b_ext_re}, 32'd2);
    chk("wt addr", b_ext_addr, 32'h2000);
    chk("wt data", b_ext_dout, 32'hCAFEF00D);
    chk("wt wait stall", {31'b0, b_stall}, 32'd1);
    b_ack = 1'b1;
    #1;
    chk("wt ack stall", {31'b0, b_stall}, 32'd0);
    tick();
    b_wr = 1'b0;
    tick();
    count_log(b_log, nw, nr);
    chk("wt miss writes", nw, 32'd1);
    chk("wt miss reads", nr, 32'd0);
    b_log.delete();
    b_re = 1'b1;
    #1;
    chk("wt no-allocate read miss", {31'b0, b_stall}, 32'd1);
    wait_b("wt read fill");
    count_log(b_log, nw, nr);
    chk("wt fill reads", nr, 32'd16);
    chk("wt fill data_out", b_dout, memf(32'h2000));
    b_re = 1'b0; b_wr = 1'b1; b_addr = 32'h2004; b_din = 32'h11112222; b_ack = 1'b0;
    #1;
    chk("wt hit stall", {31'b0, b_stall}, 32'd1);
    tick();
    chk("wt hit addr", b_ext_addr, 32'h2004);
    chk("wt hit data", b_ext_dout, 32'h11112222);
    b_ack = 1'b1;
    tick();
    b_wr = 1'b0; b_re = 1'b1;
    #1;
    chk("wt hit read stall", {31'b0, b_stall}, 32'd0);
    chk("wt hit read data", b_dout, 32'h11112222);
    b_re = 1'b0;
    tick();

    chk("wb ext_wr&ext_re overlap", a_both, 32'd0);
    chk("wt ext_wr&ext_re overlap", b_both, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
